// File: rtl/tlb_plru_pkg.sv
// Shared encodings, entry type and permission rule for the fully associative PLRU TLB.
package tlb_plru_pkg;

  localparam logic [1:0] TLB_OP_LOOKUP  = 2'b00;
  localparam logic [1:0] TLB_OP_INV_ALL = 2'b01;
  localparam logic [1:0] TLB_OP_INV_VA  = 2'b10;

  localparam logic [2:0] MMU_FAULT_NONE = 3'd0;
  localparam logic [2:0] MMU_FAULT_PF   = 3'd1;

  localparam int unsigned TLB_PAGE_SHIFT = 12;
  localparam int unsigned PageW          = 32 - TLB_PAGE_SHIFT;

  typedef enum logic [1:0] {StIdle, StWalk, StWalkStale} walk_state_e;

  typedef struct packed {
    logic             valid;
    logic [PageW-1:0] ea;
    logic [PageW-1:0] pa;
    logic [1:0]       pp;
    logic             kp;
    logic             ks;
    logic             cacheable;
  } tlb_entry_t;

  function automatic logic perm_fault(input logic [1:0] pp, input logic key, input logic rnw);
    return (pp == 2'b11 && !rnw) || (key && pp == 2'b00) || (key && pp == 2'b01 && !rnw);
  endfunction

endpackage

// File: rtl/plru_tree.sv
// Tree pseudo-LRU state: touch points the path away from an entry, victim follows the bits.
module plru_tree #(
  parameter int unsigned ENTRIES = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clear_i,
  input  logic                       touch_valid_i,
  input  logic [$clog2(ENTRIES)-1:0] touch_idx_i,
  output logic [$clog2(ENTRIES)-1:0] victim_o
);
  localparam int unsigned IdxW = $clog2(ENTRIES);

  // Heap order: root is node 1, children of n are 2n (left) and 2n+1; a 0 bit means victim left.
  logic [ENTRIES-1:1] bits_q, bits_d;

  always_comb begin : touch_logic
    bits_d = bits_q;
    if (clear_i) begin
      bits_d = '0;
    end else if (touch_valid_i) begin
      for (int l = 0; l < int'(IdxW); l++) begin
        bits_d[IdxW'((ENTRIES + 32'(touch_idx_i)) >> (IdxW - 32'(l)))] =
            ~1'(32'(touch_idx_i) >> (IdxW - 1 - 32'(l)));
      end
    end
  end

  always_comb begin : victim_logic
    int unsigned node;
    node = 1;
    for (int l = 0; l < int'(IdxW); l++) begin
      node = 2 * node + 32'(bits_q[IdxW'(node)]);
    end
    victim_o = IdxW'(node - ENTRIES);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bits_q <= '0;
    end else begin
      bits_q <= bits_d;
    end
  end

endmodule

// File: rtl/tlb_plru.sv
// Fully associative TLB: combinational lookup/permission check, PLRU refill, walker request FSM.
module tlb_plru
  import tlb_plru_pkg::*;
#(
  parameter int unsigned ENTRIES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  operation,
  input  logic        enable,
  input  logic        privileged,
  input  logic        RnW,
  input  logic [31:0] virtual_addr,
  output logic [31:0] physical_addr,
  output logic        cacheable,
  output logic        hit,
  output logic [2:0]  fault_type,
  output logic        multi_hit,
  output logic        walk_req,
  output logic [31:0] walk_addr,
  input  logic        load,
  input  logic        walk_fail,
  input  logic [31:0] new_ea,
  input  logic [31:0] new_pa,
  input  logic [1:0]  new_pp,
  input  logic        new_Kp,
  input  logic        new_Ks,
  input  logic        new_cacheable
);
  localparam int unsigned IdxW = $clog2(ENTRIES);

  tlb_entry_t       entries_q [ENTRIES];
  tlb_entry_t       entries_d [ENTRIES];
  walk_state_e      state_q, state_d;
  logic [PageW-1:0] walk_page_q, walk_page_d;
  logic             multi_hit_q, multi_hit_d;

  logic [PageW-1:0]   va_page, new_page, pa_or, pa_sel;
  logic               is_lookup, is_inv_all, is_inv_va;
  logic [ENTRIES-1:0] match;
  logic               any_match, many_match, any_invalid;
  logic [IdxW-1:0]    hit_idx, free_idx, tree_victim, victim_idx, touch_idx;
  logic [1:0]         pp_or;
  logic               kp_or, ks_or, cache_or, install, touch_valid;
  logic               unused_page_offsets;

  assign va_page    = virtual_addr[31:TLB_PAGE_SHIFT];
  assign new_page   = new_ea[31:TLB_PAGE_SHIFT];
  assign is_lookup  = enable && (operation == TLB_OP_LOOKUP);
  assign is_inv_all = enable && (operation == TLB_OP_INV_ALL);
  assign is_inv_va  = enable && (operation == TLB_OP_INV_VA);
  assign unused_page_offsets = ^{new_ea[TLB_PAGE_SHIFT-1:0], new_pa[TLB_PAGE_SHIFT-1:0]};

  always_comb begin : match_or
    match       = '0;
    any_match   = 1'b0;
    many_match  = 1'b0;
    hit_idx     = '0;
    pa_or       = '0;
    pp_or       = '0;
    kp_or       = 1'b0;
    ks_or       = 1'b0;
    cache_or    = 1'b0;
    any_invalid = 1'b0;
    free_idx    = '0;
    for (int i = 0; i < int'(ENTRIES); i++) begin
      match[i] = entries_q[i].valid && (entries_q[i].ea == va_page);
      if (match[i]) begin
        if (any_match) many_match = 1'b1;
        else hit_idx = IdxW'(i);
        any_match = 1'b1;
        pa_or     = pa_or | entries_q[i].pa;
        pp_or     = pp_or | entries_q[i].pp;
        kp_or     = kp_or | entries_q[i].kp;
        ks_or     = ks_or | entries_q[i].ks;
        cache_or  = cache_or | entries_q[i].cacheable;
      end
      if (!entries_q[i].valid && !any_invalid) begin
        any_invalid = 1'b1;
        free_idx    = IdxW'(i);
      end
    end
  end

  assign hit           = is_lookup && any_match;
  assign pa_sel        = hit ? pa_or : '0;
  assign physical_addr = {pa_sel, virtual_addr[TLB_PAGE_SHIFT-1:0]};
  assign cacheable     = hit && cache_or;
  assign fault_type    = (hit && perm_fault(pp_or, privileged ? ks_or : kp_or, RnW)) ?
                         MMU_FAULT_PF : MMU_FAULT_NONE;
  assign multi_hit     = multi_hit_q;
  assign walk_req      = (state_q != StIdle);
  assign walk_addr     = {walk_page_q, {TLB_PAGE_SHIFT{1'b0}}};
  assign victim_idx    = any_invalid ? free_idx : tree_victim;

  always_comb begin : next_state
    state_d     = state_q;
    walk_page_d = walk_page_q;
    multi_hit_d = multi_hit_q | (is_lookup && many_match);
    install     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (is_lookup && !any_match) begin
          state_d     = StWalk;
          walk_page_d = va_page;
        end
      end
      StWalk: begin
        if (load) begin
          state_d = StIdle;
          install = !is_inv_all && !(is_inv_va && (new_page == va_page));
        end else if (walk_fail) begin
          state_d = StIdle;
        end else if (is_inv_all || (is_inv_va && (va_page == walk_page_q))) begin
          state_d = StWalkStale;
        end
      end
      StWalkStale: begin
        if (load || walk_fail) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    entries_d = entries_q;
    for (int i = 0; i < int'(ENTRIES); i++) begin
      if (is_inv_all || (is_inv_va && match[i])) entries_d[i].valid = 1'b0;
    end
    if (install) begin
      entries_d[victim_idx] = {1'b1, new_page, new_pa[31:TLB_PAGE_SHIFT], new_pp,
                               new_Kp, new_Ks, new_cacheable};
    end
  end

  // A refill takes the single touch when it coincides with a lookup hit.
  assign touch_valid = install || hit;
  assign touch_idx   = install ? victim_idx : hit_idx;

  plru_tree #(
    .ENTRIES(ENTRIES)
  ) u_plru_tree (
    .clk          (clk),
    .reset        (reset),
    .clear_i      (is_inv_all),
    .touch_valid_i(touch_valid),
    .touch_idx_i  (touch_idx),
    .victim_o     (tree_victim)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      walk_page_q <= '0;
      multi_hit_q <= 1'b0;
      for (int i = 0; i < int'(ENTRIES); i++) begin
        entries_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      walk_page_q <= walk_page_d;
      multi_hit_q <= multi_hit_d;
      entries_q   <= entries_d;
    end
  end

endmodule

// File: tb/tb_tlb_plru.sv
// Randomized scoreboard bench for tlb_plru against a timestamp-based PLRU reference model.
module tb_tlb_plru;
  import tlb_plru_pkg::*;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  operation;
  logic        enable, privileged, RnW;
  logic [31:0] virtual_addr, physical_addr, walk_addr, new_ea, new_pa;
  logic        cacheable, hit, multi_hit, walk_req, load, walk_fail;
  logic [2:0]  fault_type;
  logic [1:0]  new_pp;
  logic        new_Kp, new_Ks, new_cacheable;

  tlb_plru #(.ENTRIES(N)) dut (
    .clk(clk), .reset(reset), .operation(operation), .enable(enable),
    .privileged(privileged), .RnW(RnW), .virtual_addr(virtual_addr),
    .physical_addr(physical_addr), .cacheable(cacheable), .hit(hit),
    .fault_type(fault_type), .multi_hit(multi_hit), .walk_req(walk_req),
    .walk_addr(walk_addr), .load(load), .walk_fail(walk_fail), .new_ea(new_ea),
    .new_pa(new_pa), .new_pp(new_pp), .new_Kp(new_Kp), .new_Ks(new_Ks),
    .new_cacheable(new_cacheable)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        hit;
    logic [31:0] pa;
    logic        cach;
    logic [2:0]  fault;
    logic        mh;
    logic        wr;
    logic [31:0] wa;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference state: per-entry contents plus a last-touch timestamp (0 = untouched since clear).
  logic        m_valid[N];
  logic [19:0] m_ea[N], m_pa[N];
  logic [1:0]  m_pp[N];
  logic        m_kp[N], m_ks[N], m_c[N];
  int          m_stamp[N];
  int          m_now, m_mode;
  logic [19:0] m_walk_page;
  logic        m_multi;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      m_valid[i] = 0; m_ea[i] = 0; m_pa[i] = 0; m_pp[i] = 0;
      m_kp[i] = 0; m_ks[i] = 0; m_c[i] = 0; m_stamp[i] = 0;
    end
    m_now = 0; m_mode = 0; m_walk_page = 0; m_multi = 0;
  endfunction

  // Each tree node points away from the most recently touched entry in its range.
  function automatic int model_victim();
    int lo = 0, hi = N;
    for (int i = 0; i < N; i++) if (!m_valid[i]) return i;
    while (hi - lo > 1) begin
      int mid = (lo + hi) / 2;
      int best = -1, bs = 0;
      for (int i = lo; i < hi; i++) if (m_stamp[i] > bs) begin bs = m_stamp[i]; best = i; end
      if (best == -1 || best >= mid) hi = mid;
      else lo = mid;
    end
    return lo;
  endfunction

  function automatic exp_t model_expect();
    exp_t e;
    int n = 0;
    logic [19:0] pa = 0;
    logic [1:0] pp = 0;
    logic kp = 0, ks = 0, c = 0, key, f;
    logic lk = enable && (operation == TLB_OP_LOOKUP);
    for (int i = 0; i < N; i++) begin
      if (m_valid[i] && m_ea[i] == virtual_addr[31:12]) begin
        n++; pa |= m_pa[i]; pp |= m_pp[i]; kp |= m_kp[i]; ks |= m_ks[i]; c |= m_c[i];
      end
    end
    key = privileged ? ks : kp;
    case (pp)
      2'b00: f = key;
      2'b01: f = key && !RnW;
      2'b10: f = 0;
      default: f = !RnW;
    endcase
    e.hit   = lk && n > 0;
    e.pa    = {e.hit ? pa : 20'h0, virtual_addr[11:0]};
    e.cach  = e.hit && c;
    e.fault = (e.hit && f) ? MMU_FAULT_PF : MMU_FAULT_NONE;
    e.mh    = m_multi;
    e.wr    = m_mode != 0;
    e.wa    = {m_walk_page, 12'h000};
    return e;
  endfunction

  function automatic void model_commit();
    logic lk = enable && (operation == TLB_OP_LOOKUP);
    logic ia = enable && (operation == TLB_OP_INV_ALL);
    logic iv = enable && (operation == TLB_OP_INV_VA);
    logic [19:0] vp = virtual_addr[31:12];
    int first = -1, n = 0, vic;
    logic inst = 0;
    for (int i = 0; i < N; i++)
      if (m_valid[i] && m_ea[i] == vp) begin n++; if (first < 0) first = i; end
    vic = model_victim();
    if (lk && n > 1) m_multi = 1;
    case (m_mode)
      0: if (lk && n == 0) begin m_mode = 1; m_walk_page = vp; end
      1: begin
        if (load) begin
          m_mode = 0;
          inst = !ia && !(iv && new_ea[31:12] == vp);
        end else if (walk_fail) m_mode = 0;
        else if (ia || (iv && vp == m_walk_page)) m_mode = 2;
      end
      default: if (load || walk_fail) m_mode = 0;
    endcase
    if (ia) for (int i = 0; i < N; i++) begin m_valid[i] = 0; m_stamp[i] = 0; end
    if (iv) for (int i = 0; i < N; i++) if (m_valid[i] && m_ea[i] == vp) m_valid[i] = 0;
    if (inst) begin
      m_valid[vic] = 1; m_ea[vic] = new_ea[31:12]; m_pa[vic] = new_pa[31:12];
      m_pp[vic] = new_pp; m_kp[vic] = new_Kp; m_ks[vic] = new_Ks; m_c[vic] = new_cacheable;
      m_now++; m_stamp[vic] = m_now;
    end else if (lk && n > 0) begin
      m_now++; m_stamp[first] = m_now;
    end
  endfunction

  task automatic step(input logic en, input logic [1:0] op, input logic [31:0] va,
                      input logic priv, input logic rnw, input logic ld, input logic wf,
                      input logic [31:0] nea, input logic [31:0] npa, input logic [1:0] npp,
                      input logic nkp, input logic nks, input logic nc);
    @(posedge clk); #1;
    enable = en; operation = op; virtual_addr = va; privileged = priv; RnW = rnw;
    load = ld; walk_fail = wf; new_ea = nea; new_pa = npa; new_pp = npp;
    new_Kp = nkp; new_Ks = nks; new_cacheable = nc;
    exp_q.push_back(model_expect());
    model_commit();
  endtask

  task automatic look(input logic [31:0] va, input logic priv = 1, input logic rnw = 1);
    step(1, TLB_OP_LOOKUP, va, priv, rnw, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic nop();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic fill(input logic [31:0] ea, input logic [31:0] pa, input logic [1:0] pp,
                      input logic kp, input logic ks, input logic c);
    step(0, 0, 0, 0, 0, 1, 0, ea, pa, pp, kp, ks, c);
  endtask
  task automatic fail_walk();
    step(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic tlbi(input logic [1:0] op, input logic [31:0] va);
    step(1, op, va, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic fill_four();
    tlbi(TLB_OP_INV_ALL, 0);
    for (int p = 1; p <= 4; p++) begin
      look(32'(p) << 12);
      fill(32'(p) << 12, 32'(p + 16) << 12, 2'b10, 0, 0, 1);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("hit", hit, mon_e.hit);
      chk("physical_addr", physical_addr, mon_e.pa);
      chk("cacheable", cacheable, mon_e.cach);
      chk("fault_type", fault_type, mon_e.fault);
      chk("multi_hit", multi_hit, mon_e.mh);
      chk("walk_req", walk_req, mon_e.wr);
      chk("walk_addr", walk_addr, mon_e.wa);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, required normal finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    reset = 1; enable = 1; operation = TLB_OP_LOOKUP; virtual_addr = 32'h0000_0abc;
    privileged = 0; RnW = 0; load = 0; walk_fail = 0; new_ea = 0; new_pa = 0;
    new_pp = 0; new_Kp = 0; new_Ks = 0; new_cacheable = 0;
    model_reset();
    #12;
    chk("rst_hit", hit, 0);
    chk("rst_pa", physical_addr, 32'h0000_0abc);
    chk("rst_fault", fault_type, MMU_FAULT_NONE);
    chk("rst_walk_req", walk_req, 0);
    chk("rst_walk_addr", walk_addr, 0);
    enable = 0;
    @(negedge clk); reset = 0;

    // Basic miss / refill / hit
    look(32'h1234_5678); nop();
    fill(32'h1234_5000, 32'h0008_0000, 2'b10, 0, 0, 1);
    look(32'h1234_5678);

    // PLRU replacement: page 2 is the victim after touching 1 and 3
    fill_four();
    look(32'h1000); look(32'h3000); look(32'h5000);
    fill(32'h5000, 32'h0002_5000, 2'b10, 0, 0, 0);
    for (int p = 1; p <= 5; p++) look(32'(p) << 12);
    fail_walk();

    // Permissions
    tlbi(TLB_OP_INV_ALL, 0); look(32'h9000);
    fill(32'h9000, 32'h0005_5000, 2'b01, 1, 0, 0);
    look(32'h9abc, 0, 0); look(32'h9abc, 0, 1); look(32'h9abc, 1, 0);

    // Stale walk after TLBI ALL
    look(32'h7000); tlbi(TLB_OP_INV_ALL, 0);
    fill(32'h7000, 32'h0007_7000, 2'b10, 0, 0, 1);
    nop(); look(32'h7000); nop(); fail_walk();

    // TLBI VA then invalid-first refill, plus invalidate/load coincidence
    fill_four();
    tlbi(TLB_OP_INV_VA, 32'h3000); look(32'h3123);
    fill(32'h3000, 32'h0003_3000, 2'b00, 0, 1, 1);
    look(32'h3123, 1, 0); look(32'h6000);
    step(1, TLB_OP_INV_VA, 32'h6000, 0, 0, 1, 0, 32'h6000, 32'h0006_6000, 2'b10, 0, 0, 1);
    look(32'h6000);
    step(1, TLB_OP_INV_VA, 32'h1000, 0, 0, 1, 0, 32'h6000, 32'h0006_6000, 2'b10, 0, 0, 1);
    look(32'h6000); look(32'h1000); fail_walk();

    // Async reset mid-walk
    look(32'h8000); nop();
    @(negedge clk); #2;
    reset = 1; #1;
    chk("async_walk_req", walk_req, 0);
    chk("async_walk_addr", walk_addr, 0);
    chk("async_multi_hit", multi_hit, 0);
    exp_q.delete();
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 0;
    fill(32'h8000, 32'h0008_8000, 2'b10, 0, 0, 1);
    look(32'h8000); fill(32'h8000, 32'h0008_8000, 2'b10, 0, 0, 1); look(32'h8000);

    // Randomized traffic over a small page set
    for (int c = 0; c < 1500; c++) begin
      logic ld, wf, en;
      logic [1:0] op;
      logic [31:0] va, nea;
      ld  = ($urandom_range(0, 3) == 0) && (m_mode != 0 || $urandom_range(0, 7) == 0);
      wf  = !ld && m_mode != 0 && ($urandom_range(0, 9) == 0);
      en  = $urandom_range(0, 7) != 0;
      op  = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : TLB_OP_LOOKUP;
      va  = (32'($urandom_range(1, 7)) << 12) | 32'($urandom_range(0, 4095));
      nea = ($urandom_range(0, 4) == 0) ? (32'($urandom_range(1, 7)) << 12)
                                        : {m_walk_page, 12'h000};
      step(en, op, va, 1'($urandom()), 1'($urandom()), ld, wf, nea,
           32'($urandom()), 2'($urandom()), 1'($urandom()), 1'($urandom()), 1'($urandom()));
    end

    nop(); nop();
    @(negedge clk); #1;
    chk("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
